// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding memory read,
// and a small prefetch FIFO that presents instruction bytes to the decoder.
module fetch_unit #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 2,
    parameter logic [7:0]  HALT_INSTR = 8'hFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ena,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN,
        ST_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              halted_q, halted_d;
    logic [7:0]        fifo_q [DEPTH];
    logic [7:0]        fifo_d [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [7:0]        out_q, out_d;

    logic ack;
    logic push;
    logic pop;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = req_q;
        halted_d = halted_q;
        fifo_d   = fifo_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;

        ack  = req_q & mem_ack;
        pop  = (cnt_q != '0) & instr_ready & ena;
        push = ack & (state_q == ST_REQ) & ~pc_load;

        if (push) begin
            fifo_d[wr_q] = mem_rdata;
            wr_d         = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (pc_load) begin
            // Redirect wins over push/pop; an unacked request is kept on the bus
            // and its data thrown away in DRAIN.
            rd_d     = '0;
            wr_d     = '0;
            cnt_d    = '0;
            pc_d     = pc_load_addr;
            halted_d = 1'b0;
            addr_d   = addr_q;
            if ((state_q == ST_REQ || state_q == ST_DRAIN) && !ack) begin
                state_d = ST_DRAIN;
                req_d   = 1'b1;
            end else begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ena && !halted_q && (cnt_q < FULL)) begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (mem_rdata == HALT_INSTR) begin
                            state_d  = ST_HALT;
                            req_d    = 1'b0;
                            halted_d = 1'b1;
                        end else if (ena && (cnt_d < FULL)) begin
                            addr_d = pc_q + ADDR_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ack) begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
            endcase
        end

        valid_d = (cnt_d != '0);
        out_d   = valid_d ? fifo_d[rd_d] : 8'h00;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            out_q    <= 8'h00;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            fifo_q   <= fifo_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign pc_out      = pc_q;
    assign instr_out   = out_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared against a byte-stream model of program memory.
module tb_fetch_unit;

    localparam int unsigned AW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          ena;
    logic          pc_load;
    logic [AW-1:0] pc_load_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_rdata;
    logic [7:0]    instr_out;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc_out;
    logic          halted;

    int total = 0;
    int bad   = 0;

    logic [7:0]    mem_m [256];
    logic [AW-1:0] ack_log [$];
    logic [7:0]    out_log [$];
    int unsigned   lat    = 0;
    int unsigned   wait_n = 0;

    fetch_unit #(
        .ADDR_W    (AW),
        .DEPTH     (2),
        .HALT_INSTR(8'hFF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ena         (ena),
        .pc_load     (pc_load),
        .pc_load_addr(pc_load_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory responds after `lat` wait cycles, pops and acks are logged.
    task automatic tick();
        logic          acked;
        logic          popping;
        logic          prev_req;
        logic [AW-1:0] a;
        logic [7:0]    pb;
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (mem_req === 1'b1 && wait_n >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_m[mem_addr];
        end
        acked    = mem_ack;
        a        = mem_addr;
        prev_req = (mem_req === 1'b1);
        popping  = (instr_valid === 1'b1) && instr_ready && ena;
        pb       = instr_out;
        @(posedge clock);
        if (acked) ack_log.push_back(a);
        if (popping) out_log.push_back(pb);
        if (acked || !prev_req) wait_n = 0;
        else wait_n++;
        @(negedge clock);
        mem_ack = 1'b0;
        if (prev_req && !acked && reset_n)
            chk("req_hold", 32'({mem_req, mem_addr}), 32'({1'b1, a}));
    endtask

    task automatic do_reset(input logic e, input logic r);
        reset_n = 1'b0;
        pc_load = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_req",    32'(mem_req), 0);
        chk("rst_addr",   32'(mem_addr), 0);
        chk("rst_pc",     32'(pc_out), 0);
        chk("rst_valid",  32'(instr_valid), 0);
        chk("rst_out",    32'(instr_out), 0);
        chk("rst_halted", 32'(halted), 0);
        ack_log.delete();
        out_log.delete();
        wait_n      = 0;
        ena         = e;
        instr_ready = r;
        reset_n     = 1'b1;
    endtask

    initial begin
        int          n;
        int          m;
        int          b;
        int unsigned s;
        logic [7:0]  idx;

        reset_n      = 1'b0;
        ena          = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        instr_ready  = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'(i + 16);

        // 1: zero-wait streaming
        lat = 0;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t1_req",   32'(mem_req), 1);
            chk("t1_addr",  32'(mem_addr), k - 1);
            chk("t1_valid", 32'(instr_valid), (k >= 2) ? 1 : 0);
            if (k >= 2) chk("t1_out", 32'(instr_out), 16 + k - 2);
        end

        // 2: decoder stalled, FIFO fills to DEPTH
        do_reset(1'b1, 1'b0);
        repeat (6) tick();
        chk("t2_acks",  ack_log.size(), 2);
        chk("t2_a0",    32'(ack_log[0]), 0);
        chk("t2_a1",    32'(ack_log[1]), 1);
        chk("t2_req",   32'(mem_req), 0);
        chk("t2_pc",    32'(pc_out), 2);
        chk("t2_out",   32'(instr_out), 8'h10);
        chk("t2_valid", 32'(instr_valid), 1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_out2", 32'(instr_out), 8'h11);
        tick();
        chk("t2_req2",  32'(mem_req), 1);
        chk("t2_addr2", 32'(mem_addr), 2);

        // 3: three wait cycles per request
        lat = 3;
        do_reset(1'b1, 1'b1);
        repeat (30) tick();
        chk("t3_acks", ack_log.size(), 7);
        chk("t3_pops", out_log.size(), 7);
        foreach (ack_log[i]) chk("t3_addr", 32'(ack_log[i]), i);
        foreach (out_log[i]) chk("t3_data", 32'(out_log[i]), 16 + i);

        // 4: HALT stops fetch, pc_load restarts it
        mem_m[3] = 8'hFF;
        lat = 0;
        do_reset(1'b1, 1'b1);
        repeat (10) tick();
        chk("t4_acks", ack_log.size(), 4);
        foreach (ack_log[i]) chk("t4_addr", 32'(ack_log[i]), i);
        chk("t4_pops", out_log.size(), 4);
        chk("t4_d0", 32'(out_log[0]), 8'h10);
        chk("t4_d1", 32'(out_log[1]), 8'h11);
        chk("t4_d2", 32'(out_log[2]), 8'h12);
        chk("t4_d3", 32'(out_log[3]), 8'hFF);
        chk("t4_halted", 32'(halted), 1);
        chk("t4_req",    32'(mem_req), 0);
        chk("t4_pc",     32'(pc_out), 4);
        chk("t4_valid",  32'(instr_valid), 0);
        pc_load      = 1'b1;
        pc_load_addr = 8'h20;
        tick();
        pc_load = 1'b0;
        chk("t4_unhalt", 32'(halted), 0);
        chk("t4_pc2",    32'(pc_out), 8'h20);
        chk("t4_req2",   32'(mem_req), 0);
        tick();
        chk("t4_req3",  32'(mem_req), 1);
        chk("t4_addr3", 32'(mem_addr), 8'h20);
        mem_m[3] = 8'h13;

        // 5: redirect while a request is outstanding
        lat = 2;
        do_reset(1'b1, 1'b1);
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr == 8'h05) && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reach", (n < 100) ? 1 : 0, 1);
        pc_load      = 1'b1;
        pc_load_addr = 8'h40;
        tick();
        pc_load = 1'b0;
        m = out_log.size();
        chk("t5_req",   32'(mem_req), 1);
        chk("t5_addr",  32'(mem_addr), 8'h05);
        chk("t5_valid", 32'(instr_valid), 0);
        chk("t5_pc",    32'(pc_out), 8'h40);
        tick();
        chk("t5_req_w", 32'(mem_req), 1);
        tick();
        chk("t5_req_d",   32'(mem_req), 0);
        chk("t5_valid_d", 32'(instr_valid), 0);
        tick();
        chk("t5_req_n",  32'(mem_req), 1);
        chk("t5_addr_n", 32'(mem_addr), 8'h40);
        repeat (12) tick();
        chk("t5_pops", out_log.size() - m, 3);
        for (int i = m; i < out_log.size(); i++)
            chk("t5_data", 32'(out_log[i]), 8'h50 + i - m);
        chk("t5_head", 32'(instr_out), 8'h53);

        // 6: address wrap, then asynchronous reset mid-request
        lat = 0;
        do_reset(1'b1, 1'b1);
        pc_load      = 1'b1;
        pc_load_addr = 8'hFE;
        tick();
        pc_load = 1'b0;
        chk("t6_pc",  32'(pc_out), 8'hFE);
        chk("t6_req", 32'(mem_req), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_req_k", 32'(mem_req), 1);
            chk("t6_addr",  32'(mem_addr), (8'hFE + k) % 256);
            if (k >= 1) chk("t6_out", 32'(instr_out), 8'h0E + k - 1);
        end
        reset_n = 1'b0;
        #1;
        chk("t6_async_req",   32'(mem_req), 0);
        chk("t6_async_valid", 32'(instr_valid), 0);
        chk("t6_async_out",   32'(instr_out), 0);
        chk("t6_async_pc",    32'(pc_out), 0);
        @(negedge clock);

        // 7: random ena / ready / latency against a memory byte-stream model
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 8'($urandom_range(0, 254));
        end
        do_reset(1'b1, 1'b1);
        s            = $urandom_range(0, 255);
        pc_load      = 1'b1;
        pc_load_addr = 8'(s);
        tick();
        pc_load = 1'b0;
        ack_log.delete();
        out_log.delete();
        for (int c = 0; c < 400; c++) begin
            ena         = ($urandom_range(0, 3) != 0);
            instr_ready = 1'($urandom_range(0, 1));
            lat         = $urandom_range(0, 2);
            tick();
            b   = ack_log.size() - out_log.size();
            idx = 8'(s + out_log.size());
            chk("rnd_occ",   (b >= 0 && b <= 2) ? 1 : 0, 1);
            chk("rnd_valid", 32'(instr_valid), (b != 0) ? 1 : 0);
            chk("rnd_out",   32'(instr_out), (b != 0) ? 32'(mem_m[idx]) : 0);
            chk("rnd_pc",    32'(pc_out), (s + ack_log.size()) % 256);
        end
        chk("rnd_progress", (out_log.size() > 50) ? 1 : 0, 1);
        foreach (ack_log[i]) chk("rnd_addr", 32'(ack_log[i]), (s + i) % 256);
        foreach (out_log[i]) begin
            idx = 8'(s + i);
            chk("rnd_data", 32'(out_log[i]), 32'(mem_m[idx]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
